// File: rtl/nibble_serial_alu.sv
// Multi-cycle ADC/SBC sequencer: one 4-bit adder stepped over 2 or 4 nibbles with
// rippled carry, per-nibble decimal correction and registered 65C816-style flags.
module nibble_serial_alu #(
  parameter bit BCD_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CI,
  input  logic        SUB,
  input  logic        BCD,
  input  logic        W16,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] RESULT,
  output logic        CO,
  output logic        VO,
  output logic        NO,
  output logic        ZO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  function automatic logic [4:0] adder4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    adder4 = {1'b0, a} + {1'b0, b} + {4'd0, ci};
  endfunction

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, bx_q, bx_d, sum_q, sum_d, result_q, result_d;
  logic [1:0]  nib_q, nib_d;
  logic        carry_q, carry_d, bcd_q, bcd_d, sub_q, sub_d, w16_q, w16_d, v_q, v_d;
  logic        co_q, co_d, vo_q, vo_d, no_q, no_d, zo_q, zo_d, done_q, done_d;

  logic        accept_s, last_s, raw_c_s, fix_c_s;
  logic [3:0]  nib_a_s, nib_b_s, raw_s_s, fix_s_s;
  logic [4:0]  add_s;

  assign accept_s = START && ((state_q == S_IDLE) || (state_q == S_FIN));
  assign BUSY     = (state_q == S_RUN) || ((state_q == S_FIN) && START);
  assign DONE     = done_q;
  assign RESULT   = result_q;
  assign CO       = co_q;
  assign VO       = vo_q;
  assign NO       = no_q;
  assign ZO       = zo_q;

  assign nib_a_s = a_q[{nib_q, 2'b00} +: 4];
  assign nib_b_s = bx_q[{nib_q, 2'b00} +: 4];
  assign add_s   = adder4(nib_a_s, nib_b_s, carry_q);
  assign raw_s_s = add_s[3:0];
  assign raw_c_s = add_s[4];
  assign last_s  = w16_q ? (nib_q == 2'd3) : (nib_q == 2'd1);

  // Decimal correction of the current nibble; subtraction keeps the borrow.
  always_comb begin
    fix_s_s = raw_s_s;
    fix_c_s = raw_c_s;
    if (bcd_q && !sub_q && (raw_c_s || (raw_s_s > 4'd9))) begin
      fix_s_s = raw_s_s + 4'd6;
      fix_c_s = 1'b1;
    end else if (bcd_q && sub_q && !raw_c_s) begin
      fix_s_s = raw_s_s + 4'd10;
      fix_c_s = 1'b0;
    end else begin
      fix_s_s = raw_s_s;
      fix_c_s = raw_c_s;
    end
  end

  // Next-state, operand latch, nibble stepping and result/flag capture.
  always_comb begin
    state_d  = state_q;
    a_d      = accept_s ? A : a_q;
    bx_d     = accept_s ? (SUB ? ~B : B) : bx_q;
    carry_d  = accept_s ? CI : carry_q;
    bcd_d    = accept_s ? (BCD & BCD_EN) : bcd_q;
    sub_d    = accept_s ? SUB : sub_q;
    w16_d    = accept_s ? W16 : w16_q;
    nib_d    = accept_s ? 2'd0 : nib_q;
    sum_d    = accept_s ? 16'd0 : sum_q;
    v_d      = v_q;
    result_d = result_q;
    co_d     = co_q;
    vo_d     = vo_q;
    no_d     = no_q;
    zo_d     = zo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = accept_s ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        sum_d[{nib_q, 2'b00} +: 4] = fix_s_s;
        carry_d = fix_c_s;
        if (last_s) begin
          // Overflow uses the uncorrected top-nibble sign, as the 65C816 does in decimal mode.
          v_d     = (nib_a_s[3] == nib_b_s[3]) && (raw_s_s[3] != nib_a_s[3]);
          state_d = S_FIN;
        end else begin
          nib_d   = nib_q + 2'd1;
          state_d = S_RUN;
        end
      end
      S_FIN: begin
        result_d = w16_q ? sum_q : {a_q[15:8], sum_q[7:0]};
        co_d     = carry_q;
        vo_d     = v_q;
        no_d     = w16_q ? sum_q[15] : sum_q[7];
        zo_d     = w16_q ? (sum_q == 16'd0) : (sum_q[7:0] == 8'd0);
        done_d   = 1'b1;
        state_d  = accept_s ? S_RUN : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      a_q      <= 16'd0;
      bx_q     <= 16'd0;
      sum_q    <= 16'd0;
      result_q <= 16'd0;
      nib_q    <= 2'd0;
      carry_q  <= 1'b0;
      bcd_q    <= 1'b0;
      sub_q    <= 1'b0;
      w16_q    <= 1'b0;
      v_q      <= 1'b0;
      co_q     <= 1'b0;
      vo_q     <= 1'b0;
      no_q     <= 1'b0;
      zo_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      bx_q     <= bx_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      nib_q    <= nib_d;
      carry_q  <= carry_d;
      bcd_q    <= bcd_d;
      sub_q    <= sub_d;
      w16_q    <= w16_d;
      v_q      <= v_d;
      co_q     <= co_d;
      vo_q     <= vo_d;
      no_q     <= no_d;
      zo_q     <= zo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: doc/nibble_serial_alu.md
Name: nibble_serial_alu

Overview:
- Multi-cycle add/subtract sequencer for the 65C816 core.
- Drives the adder4 nibble adder one nibble per clock, ripples the carry between cycles, applies decimal (BCD) correction per nibble and produces the processor flags.
- Sits between operand latch/microcode control and the P-register/accumulator writeback.
- Trades throughput for area: one adder4 instance serves 8- and 16-bit ADC/SBC.

Parameters:
- BCD_EN, 1, when 0 the BCD input is ignored and all operations are binary.

Ports:
- CLK  in  1  core clock
- RST_N  in  1  synchronous active-low reset
- START  in  1  begin operation; sampled only in IDLE or FIN
- A  in  16  operand A (accumulator)
- B  in  16  operand B (memory)
- CI  in  1  carry in (P.C)
- SUB  in  1  1 = SBC (B ones-complemented), 0 = ADC
- BCD  in  1  decimal mode (P.D)
- W16  in  1  1 = 16-bit (4 nibbles), 0 = 8-bit (2 nibbles)
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle pulse, results valid
- RESULT  out  16  sum
- CO  out  1  carry out
- VO  out  1  overflow
- NO  out  1  negative
- ZO  out  1  zero

Behaviour:
- Clock and reset: one clock CLK; reset RST_N is synchronous, active-low.
- Reset values: all outputs 0, FSM = IDLE. Reset wins over any other event, including mid-operation; partial results are discarded.
- FSM states are IDLE, RUN and FIN.
  - IDLE: when START=1, latch A, Bx (B or ~B per SUB), CI, BCD&BCD_EN and W16; set nibble index to 0; go to RUN.
  - RUN: one nibble per cycle.
    - Binary path: adder4(A nibble, Bx nibble, carry) gives s, c.
    - Decimal add: if s>9 or c=1, the nibble becomes s+6 mod 16 and carry becomes 1.
    - Decimal sub: if c=0 (borrow), the nibble becomes s+0xA mod 16 (i.e. s−6) and carry stays 0.
    - Carry is registered into the next nibble.
    - After nibble 3 (W16=1) or nibble 1 (W16=0), go to FIN.
  - FIN: DONE=1 for exactly this cycle; flags and RESULT are registered. START=1 in FIN restarts immediately (FIN→RUN, DONE still pulses); otherwise go to IDLE.
- BUSY = 1 in RUN, and in FIN only when a restart is accepted. START in RUN is ignored.
- Latency: START sampled at edge k gives DONE high during the cycle after edge k+N+1, where N = 4 or 2 nibbles. Back-to-back throughput is N+1 cycles.
- 8-bit mode:
  - RESULT[15:8] = latched A[15:8], passed unchanged.
  - Flags come from bits 7:0; NO = RESULT[7].
- 16-bit mode: NO = RESULT[15].
- ZO = 1 iff all active result bits (post-correction) are 0.
- CO = final carry after correction.
- VO = (Amsb == Bxmsb) && (Smsb != Amsb).
  - Smsb is the binary (pre-correction) top-nibble sum MSB, which matches 65C816 decimal V behaviour.
- RESULT and flags hold their last values until the next FIN; they do not change in IDLE or RUN.
- Operands are latched at START; changes to A/B/CI/SUB/BCD/W16 during RUN have no effect.

Test Plan:
- Binary 16-bit ADC: A=0x1234, B=0x4321, CI=0, W16=1 → RESULT=0x5555, CO=0, VO=0, NO=0, ZO=0; DONE exactly 5 cycles after START edge.
- BCD 8-bit ADC: A=0xAA58, B=0x0046, CI=1, BCD=1, W16=0 → RESULT=0xAA05, CO=1, ZO=0; DONE after 3 cycles.
- BCD 16-bit SBC: A=0x1000, B=0x0001, CI=1, SUB=1, BCD=1 → RESULT=0x0999, CO=1, NO=0.
- Binary 8-bit overflow and 16-bit borrow:
  - ADC A=0x007F, B=0x0001, CI=0, W16=0 → RESULT=0x0080, VO=1, NO=1, CO=0.
  - SBC 16-bit A=0x0000, B=0x0001, CI=1 → RESULT=0xFFFF, CO=0, NO=1.
- Handshake edge cases:
  - START pulsed during RUN → ignored; a single DONE.
  - START held in FIN → next op starts with no IDLE cycle.
  - RST_N=0 at nibble 2 → all outputs 0 next cycle, no DONE, accepts new START after release.
- BCD_EN=0 build: BCD=1 with A=0x0009, B=0x0001, W16=0 → RESULT=0x000A (no correction).
